// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a preloadable 64-bit-word memory.
// It accepts one AR request at a time, waits a fixed latency, and then returns
// FIXED, INCR or WRAP beats. Each beat is registered and held while rready is low.
module axi_read_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [63:0] load_data,
    input  logic        m_axi_arvalid,
    output logic        m_axi_arready,
    input  logic [63:0] m_axi_araddr,
    input  logic [7:0]  m_axi_arlen,
    input  logic [2:0]  m_axi_arsize,
    input  logic [1:0]  m_axi_arburst,
    output logic        m_axi_rvalid,
    input  logic        m_axi_rready,
    output logic [63:0] m_axi_rdata,
    output logic [1:0]  m_axi_rresp,
    output logic        m_axi_rlast
);
    localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LAT_INIT    = 32'(LATENCY - 1);
    // A byte offset from BASE_ADDR at or above this limit lies outside the memory.
    // The limit also catches addresses below BASE_ADDR, because their 65-bit difference borrows.
    localparam logic [64:0] BYTE_LIMIT  = 65'(DEPTH) << 3;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, BURST = 2'b10} state_t;

    state_t      state_r, state_s;
    logic [63:0] start_r, cur_addr_r;
    logic [7:0]  len_r, beat_r;
    logic [2:0]  size_r;
    logic [1:0]  burst_r;
    logic [31:0] lat_r;
    logic        arready_r, rvalid_r, rlast_r;
    logic [63:0] rdata_r;
    logic [1:0]  rresp_r;
    logic [63:0] mem_r [DEPTH];

    logic        capture_s, present_s, pres_err_s, load_ok_s;
    logic [63:0] pres_addr_s;
    logic [7:0]  pres_beat_s;
    logic [64:0] pres_diff_s, load_diff_s;

    // WRAP needs a power-of-two line: only 2, 4, 8 or 16 beats are legal.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok = 1'b1;
            default:                 wrap_len_ok = 1'b0;
        endcase
    endfunction

    // Address of the beat after 'cur'. WRAP wraps inside the line that holds the start address.
    function automatic logic [63:0] next_addr(input logic [63:0] cur, input logic [63:0] start,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [63:0] line_v;
        logic [63:0] base_v;
        line_v = ({56'd0, len} + 64'd1) << 3;
        base_v = start & ~(line_v - 64'd1);
        case (burst)
            BURST_FIXED: next_addr = cur;
            BURST_WRAP:  next_addr = base_v + ((cur - base_v + 64'd8) & (line_v - 64'd1));
            default:     next_addr = cur + 64'd8;
        endcase
    endfunction

    assign m_axi_arready = arready_r;
    assign m_axi_rvalid  = rvalid_r;
    assign m_axi_rdata   = rdata_r;
    assign m_axi_rresp   = rresp_r;
    assign m_axi_rlast   = rlast_r;

    // Next-state logic: decide when to capture AR and when to present a new beat.
    always_comb begin
        state_s     = state_r;
        capture_s   = 1'b0;
        present_s   = 1'b0;
        pres_addr_s = cur_addr_r;
        pres_beat_s = beat_r;
        case (state_r)
            IDLE: begin
                if (m_axi_arvalid && arready_r) begin
                    capture_s = 1'b1;
                    state_s   = WAIT;
                end else begin
                    state_s   = IDLE;
                end
            end
            WAIT: begin
                if (lat_r == 32'd0) begin
                    present_s   = 1'b1;
                    pres_addr_s = cur_addr_r;
                    pres_beat_s = 8'd0;
                    state_s     = BURST;
                end else begin
                    state_s     = WAIT;
                end
            end
            BURST: begin
                if (rvalid_r && m_axi_rready) begin
                    if (rlast_r) begin
                        state_s = IDLE;
                    end else begin
                        present_s   = 1'b1;
                        pres_addr_s = next_addr(cur_addr_r, start_r, len_r, burst_r);
                        pres_beat_s = beat_r + 8'd1;
                        state_s     = BURST;
                    end
                end else begin
                    state_s = BURST;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Address decode and per-beat error for the beat being presented and for the load port.
    always_comb begin
        pres_diff_s = {1'b0, pres_addr_s} - {1'b0, BASE_ADDR};
        load_diff_s = {1'b0, load_addr} - {1'b0, BASE_ADDR};
        pres_err_s  = (pres_diff_s >= BYTE_LIMIT) || (size_r != 3'd3) ||
                      ((burst_r == BURST_WRAP) && !wrap_len_ok(len_r));
        load_ok_s   = (load_diff_s < BYTE_LIMIT);
    end

    // Burst context, latency counter and beat tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            start_r    <= 64'd0;
            cur_addr_r <= 64'd0;
            len_r      <= 8'd0;
            size_r     <= 3'd0;
            burst_r    <= 2'b00;
            lat_r      <= 32'd0;
            beat_r     <= 8'd0;
        end else begin
            state_r <= state_s;
            if (capture_s) begin
                start_r    <= m_axi_araddr;
                len_r      <= m_axi_arlen;
                size_r     <= m_axi_arsize;
                burst_r    <= m_axi_arburst;
                lat_r      <= LAT_INIT;
                cur_addr_r <= ((m_axi_arburst == BURST_FIXED) || (m_axi_arburst == BURST_WRAP)) ?
                              m_axi_araddr : {m_axi_araddr[63:3], 3'b000};
            end else if ((state_r == WAIT) && (lat_r != 32'd0)) begin
                lat_r <= lat_r - 32'd1;
            end
            if (present_s) begin
                cur_addr_r <= pres_addr_s;
                beat_r     <= pres_beat_s;
            end
        end
    end

    // Registered AXI outputs. Beat fields change only when a new beat is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 64'd0;
            rresp_r   <= 2'b00;
        end else begin
            arready_r <= (state_s == IDLE);
            rvalid_r  <= (state_s == BURST);
            if (present_s) begin
                rdata_r <= pres_err_s ? 64'd0 : mem_r[pres_diff_s[IDX_W+2:3]];
                rresp_r <= pres_err_s ? 2'b10 : 2'b00;
                rlast_r <= (pres_beat_s == len_r);
            end
        end
    end

    // Load port. Reset does not clear the memory. A read in the same cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (load_en && load_ok_s) begin
            mem_r[load_diff_s[IDX_W+2:3]] <= load_data;
        end
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder. Each AR push computes the expected beats from
// address arithmetic over a model memory. A negedge monitor pops and compares every accepted beat.
module tb_axi_read_responder;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h0;
    localparam int          LAT   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [63:0] load_addr = 64'd0;
    logic [63:0] load_data = 64'd0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] araddr = 64'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd0;
    logic [1:0]  arburst = 2'b00;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    logic [63:0] model_mem [DEPTH];
    int          tests = 0;
    int          fails = 0;
    int          beats_seen = 0;
    int          rr_mode = 0;

    axi_read_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rlast(rlast)
    );

    always #5 clk = ~clk;

    // Reference model: compute every beat address from the burst rules and queue the expected beats.
    task automatic push_burst(input logic [63:0] start, input int len, input int size, input int burst);
        for (int n = 0; n <= len; n++) begin
            logic [63:0] a;
            logic [63:0] line;
            logic [63:0] base;
            logic        err;
            beat_t       b;
            case (burst)
                0: a = start;
                2: begin
                    line = 64'(len + 1) * 64'd8;
                    base = start & ~(line - 64'd1);
                    a    = base + ((start - base + 64'(n) * 64'd8) % line);
                end
                default: a = (start & ~64'd7) + 64'(n) * 64'd8;
            endcase
            err = (a < BASE) || ((a - BASE) / 64'd8 >= 64'(DEPTH)) || (size != 3) ||
                  ((burst == 2) && !(len inside {1, 3, 7, 15}));
            if (err) begin
                b.data = 64'd0;
                b.resp = 2'b10;
            end else begin
                b.data = model_mem[int'((a - BASE) / 64'd8)];
                b.resp = 2'b00;
            end
            b.last = (n == len);
            sb.push_back(b);
        end
    endtask

    task automatic load_word(input logic [63:0] a, input logic [63:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        if (a >= BASE && (a - BASE) / 64'd8 < 64'(DEPTH)) model_mem[int'((a - BASE) / 64'd8)] = d;
    endtask

    task automatic issue_ar(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int t;
        push_burst(a, int'(len), int'(size), int'(burst));
        arvalid = 1'b1; araddr = a; arlen = len; arsize = size; arburst = burst;
        t = 0;
        while (arready !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        tests++;
        if (arready !== 1'b1) begin
            fails++;
            $display("FAIL ar_accept: arready=%b after %0d cycles, expected 1", arready, t);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((sb.size() != 0 || rvalid === 1'b1) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        tests++;
        if (sb.size() != 0 || rvalid !== 1'b0 || arready !== 1'b1) begin
            fails++;
            $display("FAIL burst_done: pending=%0d rvalid=%b arready=%b, expected 0/0/1", sb.size(), rvalid, arready);
            sb.delete();
        end
    endtask

    // Drive rready: always high, the 1,0,0 pattern, or random.
    initial begin : rready_drv
        int k;
        k = 0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: rready = 1'b1;
                1: begin rready = (k % 3 == 0); k++; end
                default: rready = 1'b1 & $urandom_range(0, 1);
            endcase
        end
    end

    // Monitor: on each accepted beat, compare against the scoreboard. During a stall, check that the beat holds.
    initial begin : monitor
        beat_t       exp_b;
        logic        held_v;
        logic [63:0] held_d;
        logic [1:0]  held_r;
        logic        held_l;
        held_v = 1'b0; held_d = 64'd0; held_r = 2'b00; held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && rvalid === 1'b1) begin
                if (held_v) begin
                    tests++;
                    if (rdata !== held_d || rresp !== held_r || rlast !== held_l) begin
                        fails++;
                        $display("FAIL stall_hold: got %h/%b/%b, expected %h/%b/%b", rdata, rresp, rlast, held_d, held_r, held_l);
                    end
                end
                if (rready) begin
                    beats_seen++;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat: got data=%h with no beat expected", rdata);
                    end else begin
                        exp_b = sb.pop_front();
                        if (rdata !== exp_b.data || rresp !== exp_b.resp || rlast !== exp_b.last) begin
                            fails++;
                            $display("FAIL beat: got data=%h resp=%b last=%b, expected data=%h resp=%b last=%b",
                                     rdata, rresp, rlast, exp_b.data, exp_b.resp, exp_b.last);
                        end
                    end
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1; held_d = rdata; held_r = rresp; held_l = rlast;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin : stim
        int          t;
        int          b0;
        logic [63:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 64'd0 || rresp !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: arready=%b rvalid=%b rlast=%b rdata=%h rresp=%b, expected all zero",
                     arready, rvalid, rlast, rdata, rresp);
        end
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            load_word(64'(i) * 64'd8, (i < 8) ? 64'h1000 + 64'(i) : {$urandom, $urandom});

        // INCR burst of 8 beats: check first-beat latency and beat order.
        rr_mode = 0;
        issue_ar(64'h0, 8'd7, 3'd3, 2'b01);
        t = 0;
        do begin @(posedge clk); #1; t++; end while (rvalid !== 1'b1 && t < 20);
        tests++;
        if (t != LAT) begin
            fails++;
            $display("FAIL latency: got %0d cycles, expected %0d", t, LAT);
        end
        wait_done();

        // WRAP from 0x28: word order 5,6,7,0,1,2,3,4.
        issue_ar(64'h28, 8'd7, 3'd3, 2'b10);
        wait_done();

        // INCR with rready stalls: all 8 beats arrive exactly once.
        rr_mode = 1;
        b0 = beats_seen;
        issue_ar(64'h0, 8'd7, 3'd3, 2'b01);
        wait_done();
        tests++;
        if (beats_seen - b0 != 8) begin
            fails++;
            $display("FAIL stall_count: got %0d beats, expected 8", beats_seen - b0);
        end
        rr_mode = 0;

        // Crossing the end of memory, then an illegal arsize.
        issue_ar(64'h1FF8, 8'd1, 3'd3, 2'b01);
        wait_done();
        issue_ar(64'h0, 8'd1, 3'd2, 2'b01);
        wait_done();

        // Load collides with the cycle that registers word 4: the beat returns old data.
        issue_ar(64'h0, 8'd7, 3'd3, 2'b01);
        t = 0;
        while (rvalid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        repeat (3) begin @(posedge clk); #1; end
        load_en = 1'b1; load_addr = 64'h20; load_data = 64'hDEAD;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[4] = 64'hDEAD;
        wait_done();
        issue_ar(64'h20, 8'd0, 3'd3, 2'b01);
        wait_done();

        // Reset on the third beat aborts the burst.
        b0 = beats_seen;
        issue_ar(64'h0, 8'd7, 3'd3, 2'b01);
        t = 0;
        while (beats_seen < b0 + 2 && t < 100) begin @(posedge clk); #1; t++; end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            tests++;
            if (rvalid !== 1'b0 || arready !== 1'b0) begin
                fails++;
                $display("FAIL reset_abort: rvalid=%b arready=%b, expected 0/0", rvalid, arready);
            end
        end
        reset = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        tests++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: arready=%b rvalid=%b, expected 1/0", arready, rvalid);
        end
        issue_ar(64'h10, 8'd0, 3'd3, 2'b01);
        wait_done();

        // Randomized bursts with random loads in between.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) load_word(64'($urandom_range(0, 8700)), {$urandom, $urandom});
            rr_mode = $urandom_range(0, 2);
            a     = 64'($urandom_range(0, 8600));
            burst = 2'($urandom_range(0, 2));
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            if (burst == 2'b10 && $urandom_range(0, 7) != 0) begin
                case ($urandom_range(0, 3))
                    0: len = 8'd1;
                    1: len = 8'd3;
                    2: len = 8'd7;
                    default: len = 8'd15;
                endcase
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            issue_ar(a, len, size, burst);
            wait_done();
        end
        rr_mode = 0;

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_empty: %0d beats left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
